// File: rtl/aes_pkg.sv
// AES-128 shared arithmetic: S-box table, GF(2^8) helpers, Rcon and round count.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic {IDLE, RUN} aes_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word holds row 0 in its top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes128_enc_if.sv
// Block/key request and ciphertext response bus of the AES-128 core.
// AES_ENC_LAST_KEY_OUT_EN adds the final round key to the response side.
interface aes128_enc_if;
  logic [127:0] s_aes_key;
  logic [127:0] s_aes_block;
  logic         s_aes_valid;
  logic         s_aes_ready;
  logic [127:0] m_aes_block;
`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [127:0] m_aes_last_key;
`endif

  modport master (
    output s_aes_key, s_aes_block, s_aes_valid,
`ifdef AES_ENC_LAST_KEY_OUT_EN
    input  m_aes_last_key,
`endif
    input  s_aes_ready, m_aes_block
  );

  modport slave (
    input  s_aes_key, s_aes_block, s_aes_valid,
`ifdef AES_ENC_LAST_KEY_OUT_EN
    output m_aes_last_key,
`endif
    output s_aes_ready, m_aes_block
  );
endinterface

// File: rtl/aes128_enc_key_step.sv
// One AES-128 key-schedule step: round key i-1 plus Rcon[i] -> round key i.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);
  logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;
  // RotWord then SubWord on the last word; only the top byte gets Rcon.
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_out = {n0, n1, n2, n3};
endmodule

// File: rtl/aes128_enc.sv
// Iterative AES-128 encipher core, round keys expanded on the fly.
// Optional AES_ENC_LAST_KEY_OUT_EN exports the round-10 key for decrypt setup.
module aes128_enc
  import aes_pkg::*;
#(
  parameter int FAST_MODE = 0
) (
  input logic        clk,
  input logic        rst,
  aes128_enc_if.slave bus
);
  localparam bit FULL = (FAST_MODE != 0);

  aes_state_e   state, state_nxt;
  logic [127:0] st, rk, blk_out, nk;
  logic [127:0] sb, sr_in, sr, mc_full, mc, rnd_out;
  logic [3:0]   rnd;
  logic         half, last, start, adv, done;
  logic [7:0]   rcon_cur;

  always_comb begin
    rcon_cur = 8'h00;
    if (rnd >= 4'd1 && rnd <= 4'd10) rcon_cur = RCON[rnd];
  end

  aes_key_step u_key_step (.key_in(rk), .rcon(rcon_cur), .key_out(nk));

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sb[8*i +: 8] = sbox(st[8*i +: 8]);
  end

  // Half-round mode parks the SubBytes result in st, so the second half starts from st.
  assign sr_in = FULL ? sb : st;

  always_comb begin
    sr = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[127-8*(r+4*c) -: 8] = sr_in[127-8*(r+4*((c+r)%4)) -: 8];
  end

  always_comb begin
    mc_full = '0;
    for (int c = 0; c < 4; c++)
      mc_full[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
  end

  assign last    = (rnd == 4'(NR));
  assign mc      = last ? sr : mc_full;
  assign rnd_out = mc ^ nk;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // Completion is folded into the RUN->IDLE edge; there is no resident DONE cycle.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    adv       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (bus.s_aes_valid) begin
        start     = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        adv = FULL || half;
        if (adv && last) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st      <= '0;
      rk      <= '0;
      rnd     <= '0;
      half    <= 1'b0;
      blk_out <= '0;
    end else if (start) begin
      st   <= bus.s_aes_block ^ bus.s_aes_key;
      rk   <= bus.s_aes_key;
      rnd  <= 4'd1;
      half <= 1'b0;
    end else if (state == RUN) begin
      if (adv) begin
        st   <= rnd_out;
        rk   <= nk;
        rnd  <= done ? 4'd0 : rnd + 4'd1;
        half <= 1'b0;
      end else begin
        st   <= sb;
        half <= 1'b1;
      end
      if (done) blk_out <= rnd_out;
    end

  assign bus.s_aes_ready = (state == IDLE);
  assign bus.m_aes_block = blk_out;

`ifdef AES_ENC_LAST_KEY_OUT_EN
  logic [127:0] last_key;

  always_ff @(posedge clk or posedge rst)
    if (rst)       last_key <= '0;
    else if (done) last_key <= nk;

  assign bus.m_aes_last_key = last_key;
`endif

endmodule

// File: tb/tb_aes128_enc.sv
// Bench for aes128_enc: FAST_MODE 0 and 1 side by side against NIST vectors and a FIPS-197 model.
module tb_aes128_enc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes128_enc_if bus0 ();
  aes128_enc_if bus1 ();

  aes128_enc #(.FAST_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  aes128_enc #(.FAST_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] NK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NLK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic [127:0] pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                           128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  logic [127:0] ct [4] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                           128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};

  logic [7:0] sb_tab [256];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse, then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s ^= (inv << k) | (inv >> (8 - k));
      sb_tab[x] = s;
    end
  endtask

  task automatic aes_model(input logic [127:0] key, input logic [127:0] blk,
                           output logic [127:0] res, output logic [127:0] lk);
    logic [31:0] w [44];
    logic [7:0]  s [4][4];
    logic [7:0]  t [4][4];
    logic [7:0]  rc;
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = blk[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb_tab[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
          s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] ^= w[4*rd+c][31-8*r -: 8];
      end
    end
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(r+4*c) -: 8] = s[r][c];
    lk = {w[40], w[41], w[42], w[43]};
  endtask

  task automatic drive(input logic [127:0] key, input logic [127:0] blk, input logic v);
    bus0.s_aes_key = key; bus0.s_aes_block = blk; bus0.s_aes_valid = v;
    bus1.s_aes_key = key; bus1.s_aes_block = blk; bus1.s_aes_valid = v;
  endtask

  // One start pulse; busy_at>0 injects a foreign request while both cores are busy.
  task automatic run_vec(input string tag, input logic [127:0] key, input logic [127:0] blk,
                         input logic [127:0] exp, input logic [127:0] exp_lk, input int busy_at);
    int lat0, lat1;
    lat0 = -1;
    lat1 = -1;
    drive(key, blk, 1'b1);
    @(posedge clk); #1;
    drive(key, blk, 1'b0);
    chk({tag, " rdy0 after start"}, 128'(bus0.s_aes_ready), 128'd0);
    chk({tag, " rdy1 after start"}, 128'(bus1.s_aes_ready), 128'd0);
    for (int n = 1; n <= 30 && (lat0 < 0 || lat1 < 0); n++) begin
      @(posedge clk); #1;
      if (lat0 < 0 && bus0.s_aes_ready) lat0 = n;
      if (lat1 < 0 && bus1.s_aes_ready) lat1 = n;
      if (n == busy_at)     drive(~key, ~blk, 1'b1);
      if (n == busy_at + 1) drive(~key, ~blk, 1'b0);
    end
    chk({tag, " lat0"}, 128'(lat0), 128'd20);
    chk({tag, " lat1"}, 128'(lat1), 128'd10);
    chk({tag, " blk0"}, bus0.m_aes_block, exp);
    chk({tag, " blk1"}, bus1.m_aes_block, exp);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    chk({tag, " lkey0"}, bus0.m_aes_last_key, exp_lk);
    chk({tag, " lkey1"}, bus1.m_aes_last_key, exp_lk);
`endif
    @(posedge clk); #1;
    chk({tag, " rdy0 idle"}, 128'(bus0.s_aes_ready), 128'd1);
    chk({tag, " rdy1 idle"}, 128'(bus1.s_aes_ready), 128'd1);
  endtask

  // valid held high: each core restarts on its first idle cycle with the block then presented.
  task automatic run_b2b();
    logic [127:0] key, a, b, ea, eb, lk;
    int e0 [2], e1 [2];
    logic [127:0] o0 [2], o1 [2];
    int c0, c1;
    logic p0, p1;
    key = {$urandom, $urandom, $urandom, $urandom};
    a   = {$urandom, $urandom, $urandom, $urandom};
    b   = {$urandom, $urandom, $urandom, $urandom};
    aes_model(key, a, ea, lk);
    aes_model(key, b, eb, lk);
    e0 = '{-1, -1}; e1 = '{-1, -1}; o0 = '{'0, '0}; o1 = '{'0, '0};
    c0 = 0; c1 = 0; p0 = 1'b0; p1 = 1'b0;
    drive(key, a, 1'b1);
    @(posedge clk); #1;
    drive(key, b, 1'b1);
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (bus0.s_aes_ready && !p0 && c0 < 2) begin e0[c0] = n; o0[c0] = bus0.m_aes_block; c0++; end
      if (bus1.s_aes_ready && !p1 && c1 < 2) begin e1[c1] = n; o1[c1] = bus1.m_aes_block; c1++; end
      p0 = bus0.s_aes_ready;
      p1 = bus1.s_aes_ready;
      if (n == 41) drive(key, b, 1'b0);
    end
    chk("b2b edge0 A", 128'(e0[0]), 128'd20);
    chk("b2b edge0 B", 128'(e0[1]), 128'd41);
    chk("b2b edge1 A", 128'(e1[0]), 128'd10);
    chk("b2b edge1 B", 128'(e1[1]), 128'd21);
    chk("b2b blk0 A", o0[0], ea);
    chk("b2b blk0 B", o0[1], eb);
    chk("b2b blk1 A", o1[0], ea);
    chk("b2b blk1 B", o1[1], eb);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] k, p, e, lk;
    build_sbox();
    rst = 1'b1;
    drive('0, '0, 1'b0);
    #12;
    chk("reset rdy0", 128'(bus0.s_aes_ready), 128'd1);
    chk("reset rdy1", 128'(bus1.s_aes_ready), 128'd1);
    chk("reset blk0", bus0.m_aes_block, 128'd0);
    chk("reset blk1", bus1.m_aes_block, 128'd0);
`ifdef AES_ENC_LAST_KEY_OUT_EN
    chk("reset lkey0", bus0.m_aes_last_key, 128'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_vec("nist", NK, pt[i], ct[i], NLK, 0);

    run_vec("busy", NK, pt[0], ct[0], NLK, 3);

    // Abort mid-run, then confirm a clean restart.
    drive(NK, pt[1], 1'b1);
    @(posedge clk); #1;
    drive(NK, pt[1], 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort rdy0", 128'(bus0.s_aes_ready), 128'd1);
    chk("abort rdy1", 128'(bus1.s_aes_ready), 128'd1);
    chk("abort blk0", bus0.m_aes_block, 128'd0);
    chk("abort blk1", bus1.m_aes_block, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec("post-abort", NK, pt[2], ct[2], NLK, 0);

    run_b2b();

    for (int i = 0; i < 8; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      aes_model(k, p, e, lk);
      run_vec("rand", k, p, e, lk, (i % 2 == 1) ? 2 + i : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aes128_enc.md
Name: aes128_enc

Overview:
- AES-128 block encipher core (FIPS-197): one 128-bit plaintext block plus one 128-bit cipher key in, one 128-bit ciphertext block out.
- Round keys are expanded on the fly, one round key per round, from the key sampled at start.
- Iterative datapath; throughput and area are traded by parameter.
- Sits behind a crypto/stream front-end that presents blocks with a valid strobe and polls a ready flag.

Parameters:
- FAST_MODE, 0: 0 = two clocks per round (SubBytes result registered mid-round, small/fast timing); 1 = one full round per clock.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_aes_key  input  128  cipher key; bits [127:120] = key byte 0.
- s_aes_block  input  128  plaintext; bits [127:120] = state byte 0 (column-major, FIPS-197 order).
- s_aes_valid  input  1  start strobe; block and key are sampled on the rising edge where valid=1 and the core is idle.
- s_aes_ready  output  1  1 = idle and m_aes_block holds the last result (or reset value).
- m_aes_block  output  128  ciphertext, same byte order; held stable until the next completion.

Behaviour:
- Reset (async, rst=1): s_aes_ready=1, m_aes_block=0, round counter=0, FSM=IDLE, internal state/key registers=0.
- FSM states:
  - IDLE: ready=1. On valid=1, load state = block XOR key (AddRoundKey round 0), load round key = key, round=1, go to RUN, ready=0 from the next cycle.
  - RUN: apply rounds 1..10. Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey. Round 10: no MixColumns.
    - Round key i is derived from round key i-1 in the same round: RotWord, SubWord, XOR Rcon[i]. Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - DONE: at completion of round 10, write m_aes_block, set ready=1, return to IDLE in the same edge.
- Latency, from the valid-sampling edge to the edge that sets ready:
  - FAST_MODE=1: 10 clocks.
  - FAST_MODE=0: 20 clocks.
- valid while busy (ready=0): ignored, no queuing.
- valid held high while idle: a new encipherment starts on each idle cycle, back-to-back. Inputs are sampled only at start; changing key/block mid-operation has no effect.
- m_aes_block changes only at completion; it is not cleared at start.
- Reset mid-operation: immediate abort to the reset state; the partial result is discarded.
- GF(2^8) arithmetic: xtime(b) = (b<<1) XOR (0x1b if b[7]); MixColumns matrix [2 3 1 1] circulant.
- S-box: combinational constant lookup, 16 instances for state plus 4 for key.
  - FAST_MODE=0 may instead reuse the same 16 state S-boxes; cycle counts above must still hold.

Optional Feature:
- Macro AES_ENC_LAST_KEY_OUT_EN.
- Defined: adds output m_aes_last_key [127:0], the round-10 key. It is updated at the same edge as m_aes_block, reset to 0, and serves decryption key setup.
- Undefined: port absent, no extra registers.

Decomposition:
- Package aes_pkg:
  - S-box constant table and sbox() function.
  - xtime(), mix_column() and sub_word() functions.
  - Rcon array [1:10].
  - Round-count constant NR=10.
- One sub-module: aes_key_step (combinational, round key in + Rcon in -> next round key out).
- The round datapath stays in the top level.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, four NIST ECB vectors, FAST_MODE 0 and 1 instantiated in parallel:
  - 6bc1bee22e409f96e93d7e117393172a -> 3ad77bb40d7a3660a89ecaf32466ef97
  - ae2d8a571e03ac9c9eb76fac45af8e51 -> f5d3d58503b9699de785895a96fdbaaf
  - 30c81c46a35ce411e5fbc1191a0a52ef -> 43b1cd7f598ece23881b00e3ed030688
  - f69f2445df4f9b17ad2b417be66c3710 -> 7b0c785e27e8ad3f8223207104725dd4
  - Both instances must match.
- Latency: one-cycle valid pulse -> ready low on the next edge; ready high exactly 10 (FAST_MODE=1) / 20 (FAST_MODE=0) edges after the sampling edge.
- Busy: pulse valid with a different block mid-run -> result still 3ad77bb4...ef97; no second run starts.
- Reset mid-run at round 5 -> ready=1 and m_aes_block=0 immediately; a following vector then gives the correct result.
- With AES_ENC_LAST_KEY_OUT_EN: after any block under the NIST key -> m_aes_last_key = d014f9a8c9ee2589e13f0cc8b6630ca6.
